// File: rtl/nn_pkg.sv
// Types and defaults shared by the layer sequencer and the node datapath.
package nn_pkg;

   localparam int unsigned WORD_W      = 16;
   localparam int unsigned N_IN_DEF    = 64;
   localparam int unsigned ACT_LAT_DEF = 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StClr,
      StRun,
      StWait,
      StHold
   } state_t;

endpackage

// File: rtl/word_buffer.sv
// DEPTH x 16-bit register file with one write port and every word visible in parallel.
module word_buffer
   import nn_pkg::*;
#(
   parameter int unsigned DEPTH = N_IN_DEF,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    i_we,
   input  logic [AW-1:0]           i_addr,
   input  logic [WORD_W-1:0]       i_data,
   output logic [DEPTH*WORD_W-1:0] o_words
);

   word_t r_mem [DEPTH];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_addr] <= i_data;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_out
      assign o_words[g*WORD_W +: WORD_W] = r_mem[g];
   end

endmodule

// File: rtl/layer_sequencer.sv
// Loads N_IN inputs then N_IN coefficients, sweeps the node accumulator over them and
// hands the registered activation result downstream with a valid/ready handshake.
module layer_sequencer
   import nn_pkg::*;
#(
   parameter int unsigned N_IN    = N_IN_DEF,
   parameter int unsigned ACT_LAT = ACT_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   i_in_valid,
   input  logic [WORD_W-1:0]      i_in_data,
   output logic                   o_in_ready,
   input  logic                   i_abort,
   output logic [N_IN*WORD_W-1:0] o_in_val,
   output logic [N_IN*WORD_W-1:0] o_coef,
   output logic [6:0]             o_cnt_val,
   output logic                   o_acc_clr,
   output logic                   o_acc_en,
   input  logic [2:0]             i_node_result,
   output logic [2:0]             o_result_out,
   output logic                   o_result_valid,
   input  logic                   i_result_ready,
   output logic                   o_busy
);

   localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned WW = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

   state_t          r_state;
   // Write pointer split into buffer select (0 = inputs, 1 = coefficients) and word index.
   logic            r_ptr_sel;
   logic [AW-1:0]   r_ptr_idx;
   logic [6:0]      r_cnt;
   logic [WW-1:0]   r_wait;
   logic            r_in_ready;
   logic            r_acc_clr;
   logic            r_acc_en;
   logic            r_result_valid;
   logic [2:0]      r_result_out;

   logic            w_accept;
   logic            w_first;
   logic            w_wr_sel;
   logic [AW-1:0]   w_wr_idx;
   logic            w_we_in;
   logic            w_we_coef;
   logic            w_idx_top;
   logic            w_last;

   // Abort wins over a word offered on the same cycle.
   assign w_accept  = i_in_valid & r_in_ready & ~i_abort;
   assign w_first   = (r_state == StIdle);
   assign w_wr_sel  = w_first ? 1'b0 : r_ptr_sel;
   assign w_wr_idx  = w_first ? '0 : r_ptr_idx;
   assign w_we_in   = w_accept & ~w_wr_sel;
   assign w_we_coef = w_accept & w_wr_sel;
   assign w_idx_top = (r_ptr_idx == AW'(N_IN - 1));
   assign w_last    = r_ptr_sel & w_idx_top;

   word_buffer #(
      .DEPTH (N_IN),
      .AW    (AW)
   ) u_in_buf (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_we    (w_we_in),
      .i_addr  (w_wr_idx),
      .i_data  (i_in_data),
      .o_words (o_in_val)
   );

   word_buffer #(
      .DEPTH (N_IN),
      .AW    (AW)
   ) u_coef_buf (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_we    (w_we_coef),
      .i_addr  (w_wr_idx),
      .i_data  (i_in_data),
      .o_words (o_coef)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state        <= StIdle;
         r_ptr_sel      <= 1'b0;
         r_ptr_idx      <= '0;
         r_cnt          <= '0;
         r_wait         <= '0;
         r_in_ready     <= 1'b1;
         r_acc_clr      <= 1'b0;
         r_acc_en       <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_out   <= '0;
      end else if (i_abort) begin
         r_state        <= StIdle;
         r_ptr_sel      <= 1'b0;
         r_ptr_idx      <= '0;
         r_cnt          <= '0;
         r_wait         <= '0;
         r_in_ready     <= 1'b1;
         r_acc_clr      <= 1'b0;
         r_acc_en       <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_in_valid) begin
                  r_state   <= StLoad;
                  r_ptr_sel <= 1'b0;
                  r_ptr_idx <= AW'(1);
               end
            end
            StLoad: begin
               if (i_in_valid) begin
                  if (w_last) begin
                     r_state    <= StClr;
                     r_ptr_sel  <= 1'b0;
                     r_ptr_idx  <= '0;
                     r_in_ready <= 1'b0;
                     r_acc_clr  <= 1'b1;
                  end else if (w_idx_top) begin
                     r_ptr_sel <= 1'b1;
                     r_ptr_idx <= '0;
                  end else begin
                     r_ptr_idx <= r_ptr_idx + 1'b1;
                  end
               end
            end
            StClr: begin
               r_state   <= StRun;
               r_acc_clr <= 1'b0;
               r_acc_en  <= 1'b1;
               r_cnt     <= '0;
            end
            StRun: begin
               if (r_cnt == 7'(N_IN - 1)) begin
                  r_state  <= StWait;
                  r_acc_en <= 1'b0;
                  r_cnt    <= '0;
                  r_wait   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWait: begin
               if (r_wait == WW'(ACT_LAT - 1)) begin
                  r_state        <= StHold;
                  r_result_out   <= i_node_result;
                  r_result_valid <= 1'b1;
                  r_wait         <= '0;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            StHold: begin
               if (i_result_ready) begin
                  r_state        <= StIdle;
                  r_result_valid <= 1'b0;
                  r_in_ready     <= 1'b1;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_in_ready     = r_in_ready;
   assign o_cnt_val      = r_cnt;
   assign o_acc_clr      = r_acc_clr;
   assign o_acc_en       = r_acc_en;
   assign o_result_valid = r_result_valid;
   assign o_result_out   = r_result_out;
   assign o_busy         = (r_state != StIdle);

endmodule
